decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised MIPS instruction decode stage with valid/ready handshakes on both sides and an internal FIFO of pre-decoded entries. It sits between instruction fetch and register-file/ALU issue. It splits each 32-bit instruction into fields by format (R/I/J) and zero-fills the fields that do not apply. Beyond field splitting it provides opcode-selected immediate extension, jump and branch target computation, flush support, and a saturating issue counter.

## Interface
Parameters:
- `PC_W`, 32: program-counter width; must be ≥ 28.
- `DEPTH`, 2: number of FIFO entries; must be a power of two and ≥ 2.
- `CNT_W`, 16: width of the issue counter.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous discard of all buffered entries.
- `in_valid`  in  1  instruction/PC pair offered.
- `in_ready`  out  1  stage can accept this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  PC_W  address of `in_instr`.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer takes head this cycle.
- `opcode`  out  6, `rs`/`rt`/`rd`/`shamt`  out  5 each, `funct`  out  6  decoded fields.
- `imm_ext`  out  32  extended immediate.
- `address`  out  26  J-type target field.
- `fmt`  out  2  instruction format: 0 = R, 1 = I, 2 = J.
- `jump_target`  out  PC_W  `{pc4[PC_W-1:28], address, 2'b00}`.
- `branch_target`  out  PC_W  `pc4 + (sext(imm) << 2)`.
- `pc_out`  out  PC_W  PC of the head entry.
- `issue_count`  out  CNT_W  number of entries popped since reset, saturating.

## Operation
- Push occurs when `in_valid && in_ready`. Decode happens at push; the decoded fields are stored in the FIFO.
- Pop occurs when `out_valid && out_ready`. All outputs reflect the head entry.
- `in_ready` = `!reset && (count < DEPTH)`. There is no bypass when the FIFO is full.
- Field rules by opcode:
  - `0x00` (R-type): `rs`, `rt`, `rd`, `shamt`, `funct` taken from the instruction; `imm_ext` = 0, `address` = 0; `fmt` = R.
  - `0x02` (J) and `0x03` (JAL): `address` = instr[25:0]; `rs`, `rt`, `rd`, `shamt`, `funct`, `imm_ext` = 0; `fmt` = J.
  - All other opcodes (I-type): `rs`, `rt`, and the immediate are taken from the instruction; `rd`, `shamt`, `funct`, `address` = 0; `fmt` = I.
- Immediate extension: opcodes `0x0C` (andi), `0x0D` (ori), `0x0E` (xori), and `0x0F` (lui) zero-extend. All other I-type opcodes sign-extend. For R- and J-type, `imm_ext` = 0.
- `pc4` = `in_pc + 4`, computed modulo 2^PC_W.
- `branch_target` is computed for every entry, also modulo 2^PC_W. It is meaningful only for opcodes `0x04` and `0x05`. For non-I-type entries it is 0.
- `jump_target` is 0 unless `fmt` = J.
- `issue_count` increments on each pop and holds at 2^CNT_W−1 once it saturates.

## Timing
- Latency is 1 cycle. An instruction pushed at edge N is presented with `out_valid` = 1 after edge N, provided the FIFO was empty.
- Throughput is 1 instruction per cycle. When the FIFO is neither empty nor full, a simultaneous push and pop leaves the count unchanged.
- Ordering is strict FIFO. The read and write pointers wrap modulo DEPTH.
- While `out_valid` = 1 and `out_ready` = 0, all head outputs must stay stable.
- Flush:
  - When `flush` = 1 at an edge, the count and both pointers are cleared.
  - Any push offered in that same cycle is dropped.
  - No pop is counted in that cycle.
  - `out_valid` = 0 after the edge.
- Reset:
  - Reset has priority over flush.
  - After reset, `out_valid` = 0 and every data output is 0, including `issue_count`.
  - `in_ready` = 0 while `reset` is high.
  - Reset asserted mid-stream discards all entries.
- Empty FIFO: the data outputs show the last head contents, or 0 after reset. Consumers must qualify them with `out_valid`.

## Structure
- Shared package `decoder_pkg` holds:
  - opcode constants: `OP_RTYPE`, `OP_J`, `OP_JAL`, `OP_BEQ`, `OP_BNE`, `OP_ANDI`, `OP_ORI`, `OP_XORI`, `OP_LUI`;
  - the `fmt_t` enum (`FMT_R`, `FMT_I`, `FMT_J`);
  - the packed `decoded_t` struct that is stored per FIFO entry.
- One combinational sub-module, `instr_field_decode`, maps instruction + PC to `decoded_t`. The top level holds the FIFO, the handshake logic, and the counter.

## Test plan
- Reset: hold `reset` for 2 cycles, then check `out_valid` = 0, all outputs = 0, `issue_count` = 0, and `in_ready` = 1 after release.
- R-type decode: push `0x00221820` at PC `0x00400000`. Next cycle expect `rs` = 1, `rt` = 2, `rd` = 3, `funct` = `0x20`, `fmt` = R, `imm_ext` = 0.
- Immediate extension:
  - `0x2008FFFF` → `imm_ext` = `0xFFFFFFFF`;
  - `0x3408FFFF` → `imm_ext` = `0x0000FFFF`, `rt` = 8, `rd` = 0.
- Targets:
  - `beq 0x1000FFFF` at PC `0x00400010` → `branch_target` = `0x00400010`;
  - `j 0x08100000` at PC `0x00400000` → `address` = `0x0100000`, `jump_target` = `0x00400000`, `rs` = 0.
- Backpressure: hold `out_ready` = 0 and push DEPTH+1 instructions.
  - `in_ready` must drop after DEPTH accepts.
  - Release `out_ready`: all DEPTH entries drain in order, 1 per cycle, with no loss.
  - `issue_count` = DEPTH afterwards.
- Flush: with the FIFO full and `in_valid` = 1, pulse `flush`. Next cycle expect `out_valid` = 0 and `in_ready` = 1, and the offered instruction is never emitted.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and opcode constants for the MIPS decode stage.
// A decoded_t holds the format-split fields of one instruction.
package decoder_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    typedef enum logic [1:0] {
        FMT_R = 2'd0,
        FMT_I = 2'd1,
        FMT_J = 2'd2
    } fmt_t;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] imm_ext;
        logic [25:0] address;
        fmt_t        fmt;
    } decoded_t;

    // Logical immediates are zero-extended; every other I-type sign-extends.
    function automatic logic is_zero_ext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_LUI);
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and issue-side handshake bundle of the decode stage.
// The stage uses the slave view, the surrounding pipeline the master view.
interface decode_stage_if
    import decoder_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [PC_W-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       opcode;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [4:0]       shamt;
    logic [5:0]       funct;
    logic [31:0]      imm_ext;
    logic [25:0]      address;
    fmt_t             fmt;
    logic [PC_W-1:0]  jump_target;
    logic [PC_W-1:0]  branch_target;
    logic [PC_W-1:0]  pc_out;
    logic [CNT_W-1:0] issue_count;

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, opcode, rs, rt, rd, shamt, funct,
               imm_ext, address, fmt, jump_target, branch_target, pc_out, issue_count
    );

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, opcode, rs, rt, rd, shamt, funct,
               imm_ext, address, fmt, jump_target, branch_target, pc_out, issue_count
    );
endinterface

// File: rtl/instr_field_decode.sv
// Combinational split of a MIPS instruction into R/I/J fields, with
// immediate extension and jump/branch target computation from pc+4.
module instr_field_decode
    import decoder_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [31:0]     instr,
    input  logic [PC_W-1:0] pc,
    output decoded_t        fields,
    output logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] branch_target
);
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    logic [5:0]      op;
    logic [15:0]     imm;
    logic [PC_W-1:0] pc4;
    logic [PC_W-1:0] jump_full;
    logic [PC_W-1:0] branch_off;

    assign op         = instr[31:26];
    assign imm        = instr[15:0];
    assign pc4        = pc + PC_STEP;
    assign branch_off = {{(PC_W-18){imm[15]}}, imm, 2'b00};

    generate
        if (PC_W > 28) begin : g_jump_region
            assign jump_full = {pc4[PC_W-1:28], instr[25:0], 2'b00};
        end else begin : g_jump_flat
            assign jump_full = {instr[25:0], 2'b00};
        end
    endgenerate

    always_comb begin
        fields        = '0;
        fields.opcode = op;
        case (op)
            OP_RTYPE: begin
                fields.rs    = instr[25:21];
                fields.rt    = instr[20:16];
                fields.rd    = instr[15:11];
                fields.shamt = instr[10:6];
                fields.funct = instr[5:0];
                fields.fmt   = FMT_R;
            end
            OP_J, OP_JAL: begin
                fields.address = instr[25:0];
                fields.fmt     = FMT_J;
            end
            default: begin
                fields.rs      = instr[25:21];
                fields.rt      = instr[20:16];
                fields.imm_ext = is_zero_ext(op) ? {16'h0000, imm} : {{16{imm[15]}}, imm};
                fields.fmt     = FMT_I;
            end
        endcase
    end

    always_comb begin
        jump_target   = '0;
        branch_target = '0;
        if (fields.fmt == FMT_J) jump_target = jump_full;
        if (fields.fmt == FMT_I) branch_target = pc4 + branch_off;
    end
endmodule

// File: rtl/decode_stage.sv
// Registered MIPS decode stage: decodes at push, buffers pre-decoded entries
// in a small FIFO and presents the head entry with a saturating issue count.
module decode_stage
    import decoder_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input logic           clk,
    input logic           reset,
    decode_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
    localparam logic [AW:0]      CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]      CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] ISSUE_ONE = CNT_W'(1);

    typedef struct packed {
        decoded_t        f;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] jump_target;
        logic [PC_W-1:0] branch_target;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           new_entry;
    entry_t           head;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [AW-1:0]    show_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic [CNT_W-1:0] issue_count;
    logic             push;
    logic             pop;

    instr_field_decode #(.PC_W(PC_W)) u_field_decode (
        .instr         (bus.in_instr),
        .pc            (bus.in_pc),
        .fields        (new_entry.f),
        .jump_target   (new_entry.jump_target),
        .branch_target (new_entry.branch_target)
    );
    assign new_entry.pc = bus.in_pc;

    assign bus.in_ready  = !reset && (count != CNT_FULL);
    assign bus.out_valid = (count != '0);
    assign push = bus.in_valid && bus.in_ready && !bus.flush;
    assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

    always_comb begin
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (bus.flush) begin
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (pop) rd_ptr_nxt = rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count_nxt = count + CNT_ONE;
                2'b01:   count_nxt = count - CNT_ONE;
                default: count_nxt = count;
            endcase
        end
    end

    // show_ptr lags rd_ptr once the FIFO drains, so an empty stage keeps
    // presenting the entry that was last at the head.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            show_ptr    <= '0;
            count       <= '0;
            issue_count <= '0;
            // NOTE: storage is cleared because the head outputs read it directly and must be 0 after reset.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            if (bus.flush) begin
                wr_ptr <= '0;
            end else if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (count_nxt != '0) show_ptr <= rd_ptr_nxt;
            if (pop && (issue_count != '1)) issue_count <= issue_count + ISSUE_ONE;
        end
    end

    assign head              = mem[show_ptr];
    assign bus.opcode        = head.f.opcode;
    assign bus.rs            = head.f.rs;
    assign bus.rt            = head.f.rt;
    assign bus.rd            = head.f.rd;
    assign bus.shamt         = head.f.shamt;
    assign bus.funct         = head.f.funct;
    assign bus.imm_ext       = head.f.imm_ext;
    assign bus.address       = head.f.address;
    assign bus.fmt           = head.f.fmt;
    assign bus.jump_target   = head.jump_target;
    assign bus.branch_target = head.branch_target;
    assign bus.pc_out        = head.pc;
    assign bus.issue_count   = issue_count;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, field decode, immediate extension,
// targets, backpressure, throughput, flush and mid-stream reset.
module tb_decode_stage;
    import decoder_pkg::*;

    localparam int PC_W  = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    decode_stage_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    decode_stage #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] instr, input logic [PC_W-1:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;

        // Reset held for two cycles
        step();
        step();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready_low", bus.in_ready, 0);
        check("rst_opcode", bus.opcode, 0);
        check("rst_imm_ext", bus.imm_ext, 0);
        check("rst_pc_out", bus.pc_out, 0);
        check("rst_jump", bus.jump_target, 0);
        check("rst_issue", bus.issue_count, 0);
        reset = 1'b0;
        #1;
        check("rel_in_ready", bus.in_ready, 1);

        // R-type add $3,$1,$2
        push_one(32'h0022_1820, 32'h0040_0000);
        check("r_valid", bus.out_valid, 1);
        check("r_rs", bus.rs, 1);
        check("r_rt", bus.rt, 2);
        check("r_rd", bus.rd, 3);
        check("r_shamt", bus.shamt, 0);
        check("r_funct", bus.funct, 6'h20);
        check("r_fmt", bus.fmt, FMT_R);
        check("r_imm", bus.imm_ext, 0);
        check("r_pc", bus.pc_out, 32'h0040_0000);
        check("r_branch", bus.branch_target, 0);
        pop_one();
        check("r_popped", bus.out_valid, 0);
        check("issue_1", bus.issue_count, 1);

        // addi sign-extends, ori zero-extends
        push_one(32'h2008_FFFF, 32'h0040_0004);
        check("addi_imm", bus.imm_ext, 32'hFFFF_FFFF);
        check("addi_fmt", bus.fmt, FMT_I);
        pop_one();
        push_one(32'h3408_FFFF, 32'h0040_0008);
        check("ori_imm", bus.imm_ext, 32'h0000_FFFF);
        check("ori_rt", bus.rt, 8);
        check("ori_rd", bus.rd, 0);
        check("ori_addr", bus.address, 0);
        pop_one();

        // beq with offset -1: target = pc4 - 4
        push_one(32'h1000_FFFF, 32'h0040_0010);
        check("beq_target", bus.branch_target, 32'h0040_0010);
        check("beq_jump", bus.jump_target, 0);
        pop_one();

        // j, then stall to confirm the head stays stable
        push_one(32'h0810_0000, 32'h0040_0000);
        check("j_addr", bus.address, 26'h010_0000);
        check("j_target", bus.jump_target, 32'h0040_0000);
        check("j_rs", bus.rs, 0);
        check("j_fmt", bus.fmt, FMT_J);
        check("j_branch", bus.branch_target, 0);
        step();
        step();
        check("stall_valid", bus.out_valid, 1);
        check("stall_addr", bus.address, 26'h010_0000);
        pop_one();
        check("empty_valid", bus.out_valid, 0);
        check("empty_hold_addr", bus.address, 26'h010_0000);
        check("issue_5", bus.issue_count, 5);

        // Backpressure: offer DEPTH+1 with out_ready low
        for (int i = 0; i <= DEPTH; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = 32'h2008_0000 | i;
            bus.in_pc    = 32'h0000_1000 + 4 * i;
            #1;
            check($sformatf("bp_in_ready_%0d", i), bus.in_ready, (i < DEPTH) ? 1 : 0);
            step();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain_valid_%0d", i), bus.out_valid, 1);
            check($sformatf("drain_imm_%0d", i), bus.imm_ext, i);
            check($sformatf("drain_pc_%0d", i), bus.pc_out, 32'h0000_1000 + 4 * i);
            step();
        end
        bus.out_ready = 1'b0;
        check("drain_empty", bus.out_valid, 0);
        check("issue_7", bus.issue_count, 7);

        // Simultaneous push and pop on a one-entry FIFO
        push_one(32'h2009_0001, 32'h0000_2000);
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h200A_0002;
        bus.in_pc     = 32'h0000_2004;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("tp_valid", bus.out_valid, 1);
        check("tp_pc", bus.pc_out, 32'h0000_2004);
        check("tp_rt", bus.rt, 10);
        pop_one();
        check("tp_empty", bus.out_valid, 0);
        check("issue_9", bus.issue_count, 9);

        // Flush a full FIFO while a push and a pop are both offered
        push_one(32'h2008_0011, 32'h0000_3000);
        push_one(32'h2008_0022, 32'h0000_3004);
        check("full_in_ready", bus.in_ready, 0);
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h3C01_DEAD;
        bus.in_pc     = 32'h0000_3008;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        step();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("flush_valid", bus.out_valid, 0);
        check("flush_in_ready", bus.in_ready, 1);
        check("flush_issue", bus.issue_count, 9);
        push_one(32'h0085_3020, 32'h0000_4000);
        check("post_flush_rd", bus.rd, 6);
        check("post_flush_pc", bus.pc_out, 32'h0000_4000);
        pop_one();
        check("post_flush_empty", bus.out_valid, 0);
        check("issue_10", bus.issue_count, 10);

        // Reset mid-stream discards the buffered entry
        push_one(32'h0085_3020, 32'h0000_5000);
        reset = 1'b1;
        step();
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        check("mid_rst_issue", bus.issue_count, 0);
        check("mid_rst_rd", bus.rd, 0);
        check("mid_rst_pc", bus.pc_out, 0);
        reset = 1'b0;
        step();
        check("mid_rst_release", bus.in_ready, 1);
        check("mid_rst_still_empty", bus.out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
